sdram_read: RTL and testbench

Read-burst sequencer for the SDRAM controller, the counterpart of the write-burst path. On a grant from the arbiter it precharges all banks, activates the addressed row, issues a READ, and waits CAS latency. It then captures a fixed-length burst from the DQ bus and pushes each word into the read FIFO. It drives the shared command/address mux exactly as the write path does.

---
 rtl/sdram_read_pkg.sv | 21 ++
 rtl/sdram_dq_capture.sv | 48 ++++
 rtl/sdram_read.sv | 157 +++++++++++++++
 tb/tb_sdram_read.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_read_pkg.sv
// Encodings and address helpers shared by the SDRAM read and write sequencers.
package sdram_read_pkg;

  // {CKE, CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [4:0] CMD_NOP   = 5'b10111;
  localparam logic [4:0] CMD_PREC  = 5'b10010;
  localparam logic [4:0] CMD_ACT   = 5'b10011;
  localparam logic [4:0] CMD_READ  = 5'b10101;
  localparam logic [4:0] CMD_WRITE = 5'b10100;

  localparam logic [11:0] ADDR_A10_ALL = 12'h400;

  function automatic logic [11:0] addr_row(input logic [19:0] addr);
    return addr[11:0];
  endfunction

  function automatic logic [7:0] addr_col(input logic [19:0] addr);
    return addr[19:12];
  endfunction

endpackage

// File: rtl/sdram_dq_capture.sv
// DQ capture register and valid pipe; SDRAM_READ_DQ_REG_EN adds an input register on dq_i.
module sdram_dq_capture #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] dq_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] dq_s;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;

`ifdef SDRAM_READ_DQ_REG_EN
  logic [DATA_W-1:0] dq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dq_q <= '0;
    end else begin
      dq_q <= dq_i;
    end
  end

  assign dq_s = dq_q;
`else
  assign dq_s = dq_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= dq_s;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sdram_read.sv
// SDRAM read-burst sequencer: PREC, ACT, READ, CAS wait, then BURST_LEN words into the read FIFO.
// Define SDRAM_READ_DQ_REG_EN to register DQ at the input (adds one cycle of read latency).
module sdram_read
  import sdram_read_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CAS_LAT   = 3,
  parameter int unsigned TRCD      = 2
) (
  input  logic              S_CLK,
  input  logic              RST,
  input  logic              read_en,
  output logic              read_ack,
  input  logic [19:0]       sdram_addr,
  output logic [4:0]        read_cmd,
  output logic [11:0]       read_addr,
  input  logic [DATA_W-1:0] sdram_dq,
  output logic              fifo_wr_req,
  output logic [DATA_W-1:0] fifo_wr_data
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StPrec     = 3'd1;
  localparam logic [2:0] StAct      = 3'd2;
  localparam logic [2:0] StTrcdWait = 3'd3;
  localparam logic [2:0] StRd       = 3'd4;
  localparam logic [2:0] StClWait   = 3'd5;
  localparam logic [2:0] StData     = 3'd6;

`ifdef SDRAM_READ_DQ_REG_EN
  localparam int unsigned DqExtra = 1;
`else
  localparam int unsigned DqExtra = 0;
`endif

  // Wait counters are loaded with (cycles - 1) on entry and count down to zero.
  localparam int unsigned ClCycles = CAS_LAT - 1 + DqExtra;
  localparam logic [3:0]  TrcdLoad = (TRCD > 1) ? 4'(TRCD - 2) : 4'd0;
  localparam logic [3:0]  ClLoad   = 4'(ClCycles - 1);
  localparam logic [2:0]  BurstLast = 3'(BURST_LEN - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [2:0]  burst_q, burst_d;
  logic [19:0] addr_q, addr_d;
  logic [4:0]  cmd_q, cmd_d;
  logic [11:0] raddr_q, raddr_d;
  logic        ack_q, ack_d;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    ack_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (read_en) begin
          state_d = StPrec;
          addr_d  = sdram_addr;
        end
      end
      StPrec: state_d = StAct;
      StAct: begin
        if (TRCD > 1) begin
          state_d = StTrcdWait;
          wait_d  = TrcdLoad;
        end else begin
          state_d = StRd;
        end
      end
      StTrcdWait: begin
        if (wait_q == 4'd0) begin
          state_d = StRd;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StRd: begin
        state_d = StClWait;
        wait_d  = ClLoad;
      end
      StClWait: begin
        if (wait_q == 4'd0) begin
          state_d = StData;
          burst_d = 3'd0;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StData: begin
        if (burst_q == BurstLast) begin
          state_d = StIdle;
          ack_d   = 1'b1;
        end else begin
          burst_d = burst_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Command bus is registered from the next state so it lines up with the state it belongs to.
  always_comb begin
    cmd_d   = CMD_NOP;
    raddr_d = ADDR_A10_ALL;
    case (state_d)
      StPrec: cmd_d = CMD_PREC;
      StAct: begin
        cmd_d   = CMD_ACT;
        raddr_d = addr_row(addr_q);
      end
      StRd: begin
        cmd_d   = CMD_READ;
        raddr_d = {4'b0000, addr_col(addr_q)};
      end
      default: ;
    endcase
  end

  always_ff @(posedge S_CLK) begin
    if (RST) begin
      state_q <= StIdle;
      wait_q  <= 4'd0;
      burst_q <= 3'd0;
      addr_q  <= 20'd0;
      cmd_q   <= CMD_NOP;
      raddr_q <= ADDR_A10_ALL;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      raddr_q <= raddr_d;
      ack_q   <= ack_d;
    end
  end

  sdram_dq_capture #(
    .DATA_W (DATA_W)
  ) u_dq_capture (
    .clk_i   (S_CLK),
    .rst_i   (RST),
    .valid_i (state_q == StData),
    .dq_i    (sdram_dq),
    .valid_o (fifo_wr_req),
    .data_o  (fifo_wr_data)
  );

  assign read_cmd  = cmd_q;
  assign read_addr = raddr_q;
  assign read_ack  = ack_q;

endmodule

// File: tb/tb_sdram_read.sv
// Scoreboard bench for sdram_read: instance 0 uses defaults, instance 1 uses CAS_LAT=2, TRCD=1.
module tb_sdram_read;

  localparam logic [4:0] C_NOP  = 5'b10111;
  localparam logic [4:0] C_PREC = 5'b10010;
  localparam logic [4:0] C_ACT  = 5'b10011;
  localparam logic [4:0] C_READ = 5'b10101;
  localparam int BL  = 4;
  localparam int BIG = 1000000;
`ifdef SDRAM_READ_DQ_REG_EN
  localparam int X = 1;
`else
  localparam int X = 0;
`endif

  typedef struct {
    int          cyc;
    logic [4:0]  cmd;
    logic [11:0] addr;
  } cmd_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en    [2];
  logic [19:0] addr  [2];
  logic [15:0] dq    [2];
  logic        ack   [2];
  logic [4:0]  cmd   [2];
  logic [11:0] raddr [2];
  logic        wr    [2];
  logic [15:0] wdata [2];

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  int   nb [2] = '{0, 0};
  cmd_t cq [2][$];
  wr_t  wq [2][$];
  int   aq [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdram_read #(.DATA_W(16), .BURST_LEN(4), .CAS_LAT(3), .TRCD(2)) u_dut0 (
    .S_CLK(clk), .RST(rst), .read_en(en[0]), .read_ack(ack[0]), .sdram_addr(addr[0]),
    .read_cmd(cmd[0]), .read_addr(raddr[0]), .sdram_dq(dq[0]), .fifo_wr_req(wr[0]),
    .fifo_wr_data(wdata[0])
  );

  sdram_read #(.DATA_W(16), .BURST_LEN(4), .CAS_LAT(2), .TRCD(1)) u_dut1 (
    .S_CLK(clk), .RST(rst), .read_en(en[1]), .read_ack(ack[1]), .sdram_addr(addr[1]),
    .read_cmd(cmd[1]), .read_addr(raddr[1]), .sdram_dq(dq[1]), .fifo_wr_req(wr[1]),
    .fifo_wr_data(wdata[1])
  );

  function automatic int cl_of(input int i);
    return (i == 0) ? 3 : 2;
  endfunction

  function automatic int tr_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [15:0] word(input int n, input int k);
    return 16'(16'h1111 * (k + 1) + n * 16'h0010);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Called in the grant cycle; queues every event expected before cycle 'cutoff'.
  task automatic do_grant(input int i, input logic [19:0] a, input int cutoff);
    int g;
    int r;
    int d0;
    g  = cyc;
    r  = g + 2 + tr_of(i);
    d0 = r + cl_of(i) + 1 + X;
    en[i]   = 1'b1;
    addr[i] = a;
    if (g + 1 < cutoff) cq[i].push_back('{g + 1, C_PREC, 12'h400});
    if (g + 2 < cutoff) cq[i].push_back('{g + 2, C_ACT, a[11:0]});
    if (r < cutoff)     cq[i].push_back('{r, C_READ, {4'b0000, a[19:12]}});
    for (int k = 0; k < BL; k++) begin
      if (d0 + k < cutoff) wq[i].push_back('{d0 + k, word(nb[i], k)});
    end
    if (d0 + BL - 1 < cutoff) aq[i].push_back(d0 + BL - 1);
    nb[i]++;
  endtask

  // Monitor plus SDRAM data model: words follow each READ by CAS latency.
  initial begin
    int   rd_at [2];
    int   rd_n  [2];
    int   k;
    int   ea;
    cmd_t ec;
    wr_t  ew;
    rd_at = '{-100, -100};
    rd_n  = '{0, 0};
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mon_en) begin
          if (cmd[i] != C_NOP) begin
            if (cq[i].size() == 0) begin
              chk($sformatf("d%0d_unexp_cmd", i), 32'(cmd[i]), 32'(C_NOP));
            end else begin
              ec = cq[i].pop_front();
              chk($sformatf("d%0d_cmd_cyc", i), 32'(cyc), 32'(ec.cyc));
              chk($sformatf("d%0d_cmd", i), 32'(cmd[i]), 32'(ec.cmd));
              chk($sformatf("d%0d_cmd_addr", i), 32'(raddr[i]), 32'(ec.addr));
            end
          end else begin
            chk($sformatf("d%0d_nop_addr", i), 32'(raddr[i]), 32'h400);
          end
          if (wr[i]) begin
            if (wq[i].size() == 0) begin
              chk($sformatf("d%0d_unexp_wr", i), 32'(wr[i]), 32'd0);
            end else begin
              ew = wq[i].pop_front();
              chk($sformatf("d%0d_wr_cyc", i), 32'(cyc), 32'(ew.cyc));
              chk($sformatf("d%0d_wr_data", i), 32'(wdata[i]), 32'(ew.data));
            end
          end
          if (ack[i]) begin
            if (aq[i].size() == 0) begin
              chk($sformatf("d%0d_unexp_ack", i), 32'(ack[i]), 32'd0);
            end else begin
              ea = aq[i].pop_front();
              chk($sformatf("d%0d_ack_cyc", i), 32'(cyc), 32'(ea));
            end
          end
        end
        if (cmd[i] === C_READ) begin
          rd_at[i] = cyc;
          rd_n[i]++;
        end
        k = cyc - rd_at[i] - cl_of(i);
        dq[i] = (k >= 0 && k < BL) ? word(rd_n[i] - 1, k) : 16'hBEEF;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en[i]   = 1'b0;
      addr[i] = 20'd0;
    end
    repeat (3) next_cyc();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_rst_cmd", i), 32'(cmd[i]), 32'(C_NOP));
      chk($sformatf("d%0d_rst_addr", i), 32'(raddr[i]), 32'h400);
      chk($sformatf("d%0d_rst_ack", i), 32'(ack[i]), 32'd0);
      chk($sformatf("d%0d_rst_wr", i), 32'(wr[i]), 32'd0);
      chk($sformatf("d%0d_rst_wdata", i), 32'(wdata[i]), 32'd0);
    end
    next_cyc();
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (3) next_cyc();

    // Single burst; address changes after the grant must not leak in.
    do_grant(0, 20'hAB123, BIG);
    next_cyc();
    en[0]   = 1'b0;
    addr[0] = 20'hFFFFF;
    repeat (20) next_cyc();

    // Grant held high: back-to-back bursts.
    g = cyc;
    do_grant(0, 20'h5C789, BIG);
    while (cyc < g + 2 + tr_of(0) + cl_of(0) + BL + X) next_cyc();
    do_grant(0, 20'h0E456, BIG);
    next_cyc();
    en[0] = 1'b0;
    repeat (25) next_cyc();

    // Short timing instance, with a stray grant while busy.
    g = cyc;
    do_grant(1, 20'h34ABC, BIG);
    next_cyc();
    en[1] = 1'b0;
    repeat (2) next_cyc();
    en[1] = 1'b1;
    next_cyc();
    en[1] = 1'b0;
    repeat (20) next_cyc();

    // Reset in the middle of the data phase.
    g = cyc;
    do_grant(0, 20'h12FED, g + 10);
    next_cyc();
    en[0] = 1'b0;
    while (cyc < g + 9) next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cmd", 32'(cmd[0]), 32'(C_NOP));
    chk("mid_rst_addr", 32'(raddr[0]), 32'h400);
    chk("mid_rst_wr", 32'(wr[0]), 32'd0);
    chk("mid_rst_ack", 32'(ack[0]), 32'd0);
    repeat (20) next_cyc();

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_cmd_left", i), 32'(cq[i].size()), 32'd0);
      chk($sformatf("d%0d_wr_left", i), 32'(wq[i].size()), 32'd0);
      chk($sformatf("d%0d_ack_left", i), 32'(aq[i].size()), 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
